// File: rtl/traffic_pkg.sv
// Shared phase encodings and default phase durations for the traffic-light
// controller and its timing stage.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_GREEN   = 2'b00,
    PH_YELLOW  = 2'b01,
    PH_RED     = 2'b10,
    PH_INVALID = 2'b11
  } phase_e;

  localparam int DEF_PRESCALE      = 1000;
  localparam int DEF_CNT_W         = 8;
  localparam int DEF_GREEN_TICKS   = 30;
  localparam int DEF_YELLOW_TICKS  = 4;
  localparam int DEF_RED_TICKS     = 20;
  localparam int DEF_PED_GREEN_MAX = 5;

endpackage

// File: rtl/ped_req_sync.sv
// Two-flop synchroniser for an asynchronous push-button followed by a
// rising-edge detector producing a one-cycle pulse.
module ped_req_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic [1:0] sync_reg;
  logic       prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= 2'b00;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], btn};
      prev_reg <= sync_reg[1];
    end
  end

  assign pulse = sync_reg[1] & ~prev_reg;

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase timer feeding the traffic-light controller: per-phase tick countdown,
// advance request and pedestrian request handling. Optional TRAFFIC_TIMER_HOLD_EN.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int PRESCALE      = DEF_PRESCALE,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int GREEN_TICKS   = DEF_GREEN_TICKS,
  parameter int YELLOW_TICKS  = DEF_YELLOW_TICKS,
  parameter int RED_TICKS     = DEF_RED_TICKS,
  parameter int PED_GREEN_MAX = DEF_PED_GREEN_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       phase,
  input  logic             ped_btn,
`ifdef TRAFFIC_TIMER_HOLD_EN
  input  logic             hold,
`endif
  output logic             advance,
  output logic [CNT_W-1:0] remaining,
  output logic             ped_pending,
  output logic             ped_walk
);

  localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_RELOAD = PS_W'(PRESCALE - 1);

  // A zero-length phase would never be visible to the controller, so stretch it to one tick.
  localparam logic [CNT_W-1:0] GREEN_D  = (GREEN_TICKS  == 0) ? CNT_W'(1) : CNT_W'(GREEN_TICKS);
  localparam logic [CNT_W-1:0] YELLOW_D = (YELLOW_TICKS == 0) ? CNT_W'(1) : CNT_W'(YELLOW_TICKS);
  localparam logic [CNT_W-1:0] RED_D    = (RED_TICKS    == 0) ? CNT_W'(1) : CNT_W'(RED_TICKS);
  localparam logic [CNT_W-1:0] PED_MAX  = CNT_W'(PED_GREEN_MAX);

  function automatic logic [CNT_W-1:0] duration(input logic [1:0] ph);
    case (ph)
      PH_GREEN:  return GREEN_D;
      PH_YELLOW: return YELLOW_D;
      default:   return RED_D;
    endcase
  endfunction

  phase_e           phase_q;
  logic [CNT_W-1:0] remaining_reg;
  logic [PS_W-1:0]  prescale_reg;
  logic             ped_pending_reg;
  logic             ped_walk_reg;
  logic             ped_edge;
  logic             hold_active;
  logic             phase_chg;
  logic             tick;
  logic             ped_set;
  logic             shorten;

`ifdef TRAFFIC_TIMER_HOLD_EN
  assign hold_active = hold;
`else
  assign hold_active = 1'b0;
`endif

  ped_req_sync u_ped_sync (
    .clk   (clk),
    .rst   (rst),
    .btn   (ped_btn),
    .pulse (ped_edge)
  );

  assign phase_chg = (phase != phase_q);
  assign tick      = (prescale_reg == '0);
  assign ped_set   = ped_pending_reg | ped_edge;
  assign shorten   = ped_pending_reg && (phase_q == PH_GREEN) && (remaining_reg > PED_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q         <= PH_RED;
      remaining_reg   <= RED_D;
      prescale_reg    <= PS_RELOAD;
      ped_pending_reg <= 1'b0;
      ped_walk_reg    <= 1'b0;
    end else if (phase_chg) begin
      phase_q       <= phase_e'(phase);
      remaining_reg <= duration(phase);
      prescale_reg  <= PS_RELOAD;
      // A request is served by the RED entry, including one whose edge lands on this very edge.
      if ((phase == PH_RED) && ped_set) begin
        ped_walk_reg    <= 1'b1;
        ped_pending_reg <= 1'b0;
      end else begin
        ped_pending_reg <= ped_set;
        if (phase_q == PH_RED) ped_walk_reg <= 1'b0;
      end
    end else begin
      ped_pending_reg <= ped_set;
      if (!hold_active) begin
        prescale_reg <= tick ? PS_RELOAD : prescale_reg - 1'b1;
        if (shorten)
          remaining_reg <= PED_MAX;
        else if (tick && (remaining_reg != '0))
          remaining_reg <= remaining_reg - 1'b1;
      end
    end
  end

  assign advance     = (remaining_reg == '0) && !hold_active;
  assign remaining   = remaining_reg;
  assign ped_pending = ped_pending_reg;
  assign ped_walk    = ped_walk_reg;

endmodule

// File: doc/traffic_phase_timer.md
Name: traffic_phase_timer

Overview:
- Upstream timing stage for the traffic-light controller FSM. Produces the `advance` request that tells the controller to leave its current phase.
- Takes the controller's current phase back as an input. Times each phase with a per-phase duration counted in prescaled ticks.
- Latches a pedestrian push-button request. The request shortens GREEN and raises a walk indication during the next RED.

Parameters:
- PRESCALE, 1000: clk cycles per timing tick; legal range ≥2.
- CNT_W, 8: width of the phase countdown.
- GREEN_TICKS, 30: GREEN duration in ticks.
- YELLOW_TICKS, 4: YELLOW duration in ticks.
- RED_TICKS, 20: RED duration in ticks.
- PED_GREEN_MAX, 5: maximum GREEN ticks remaining once a pedestrian request is pending.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- phase  in  2  controller's current phase: 00 GREEN, 01 YELLOW, 10 RED, 11 invalid
- ped_btn  in  1  raw pedestrian button, asynchronous
- advance  out  1  level request to leave the current phase
- remaining  out  CNT_W  ticks left in the current phase
- ped_pending  out  1  a pedestrian request is latched and not yet served
- ped_walk  out  1  walk indication

Behaviour:
- Reset, while rst is high at posedge clk:
  - phase_q=RED; remaining=RED_TICKS; prescaler=PRESCALE-1.
  - advance=0; ped_pending=0; ped_walk=0; synchroniser flops=0.
- Prescaler:
  - Decrements each cycle. When it equals 0 it generates a one-cycle tick and reloads PRESCALE-1.
  - Free-running except on phase-change reload.
- Phase-change detect: the cycle in which phase != phase_q, the following all happen on the next edge:
  - phase_q<=phase.
  - remaining<=duration(phase).
  - prescaler<=PRESCALE-1.
  - Phase 11 loads RED_TICKS. A duration parameter of 0 is treated as 1.
- Countdown:
  - On a tick with remaining!=0 and no phase change, remaining decrements by 1.
  - remaining saturates at 0 and never wraps.
- advance:
  - Moore output, advance = (remaining==0).
  - Held high until the controller changes phase, which acts as the acknowledge. Drops on the edge that reloads remaining.
- Pedestrian request:
  - ped_btn passes through a 2-flop synchroniser and a rising-edge detect. The edge sets ped_pending.
  - Edges while ped_pending=1 are ignored.
- GREEN shortening:
  - Condition: ped_pending=1, phase_q==GREEN, no phase change this cycle, and remaining>PED_GREEN_MAX.
  - Action: remaining<=PED_GREEN_MAX. This overrides that cycle's decrement.
- Entering RED:
  - On the reload edge into RED with ped_pending=1: ped_walk<=1, ped_pending<=0.
  - A request edge arriving while RED is already active stays pending for the next RED.
- ped_walk clears on the reload edge that leaves RED.
- Priority, highest first: rst, phase-change reload, pedestrian shortening, tick decrement.
- Simultaneous phase change and ped edge: the reload happens and ped_pending is set. The pending flag is evaluated for walk on the next RED entry, or on this entry if the new phase is RED.
- Reset mid-phase: everything returns to reset values immediately. A pending request is lost.

Optional Feature:
- Macro: TRAFFIC_TIMER_HOLD_EN.
- When defined:
  - Adds input `hold` (1 bit), placed after ped_btn.
  - While hold=1, the prescaler and remaining are frozen and advance is forced to 0.
  - Phase-change reload and pedestrian latching still operate.
  - Release resumes from the frozen prescaler value.
- When undefined: no `hold` port; behaviour is as above.

Decomposition:
- Package traffic_pkg:
  - Phase encodings PH_GREEN=2'b00, PH_YELLOW=2'b01, PH_RED=2'b10.
  - Default duration constants, shared with the controller FSM.
- Sub-module ped_req_sync: 2-flop synchroniser plus rising-edge pulse. Reusable for other button inputs.
- Duration selection is a local function in this block.

Test Plan:
- Settings: PRESCALE=4, GREEN=6, YELLOW=2, RED=5, PED_GREEN_MAX=2.
- Reset then phase=RED held: remaining steps 5,4,3,2,1,0 every 4 cycles. advance rises 20 cycles after rst deasserts and stays high until phase changes.
- advance high, drive phase=GREEN: next edge gives remaining=6, advance=0. advance rises again 24 cycles later.
- In GREEN with remaining=5, pulse ped_btn for 3 cycles: ped_pending=1 3 cycles later and remaining forced to 2 on the following edge. Drive phase=RED: ped_walk=1, ped_pending=0. Drive phase=GREEN: ped_walk=0.
- Second ped_btn edge while ped_pending=1: no change. Edge during RED with walk active: ped_pending=1, ped_walk stays 1. Next RED entry asserts walk again.
- phase=11 applied: remaining=5, treated as a RED duration. Assert rst mid-countdown: remaining=5, advance=0, ped_pending=0 on the next edge.
- TRAFFIC_TIMER_HOLD_EN defined, hold=1 for 10 cycles at remaining=3: remaining stays 3, advance=0. After release, decrement resumes at the preserved prescaler phase.
